// File: rtl/pe_mac_seq_if.sv
// Operand/result bus of one multiply-accumulate processing element.
interface pe_mac_seq_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned RES_WIDTH = 2 * DATA_WIDTH;

  logic                  start_i;
  logic                  signed_i;
  logic                  valid_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic [DATA_WIDTH-1:0] a_o;
  logic [DATA_WIDTH-1:0] b_o;
  logic                  valid_o;
  logic [RES_WIDTH-1:0]  res_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  ovf_o;

  // PE side
  modport slave (
    input  start_i, signed_i, valid_i, a_i, b_i,
    output a_o, b_o, valid_o, res_o, busy_o, done_o, ovf_o
  );

  // Driver side
  modport master (
    output start_i, signed_i, valid_i, a_i, b_i,
    input  a_o, b_o, valid_o, res_o, busy_o, done_o, ovf_o
  );
endinterface

// File: rtl/pe_mac_seq.sv
// Sequential MAC processing element: accumulates DEPTH products per result
// and forwards its operands to the neighbouring PE one cycle later.
module pe_mac_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned SATURATE   = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  pe_mac_seq_if.slave  bus
);
  localparam int unsigned RES_W = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [RES_W-1:0]      res_q, res_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  valid_q, valid_d;

  logic signed [RES_W-1:0] a_sx, b_sx;
  logic [RES_W-1:0]        a_ux, b_ux;
  logic [RES_W-1:0]        prod;
  logic [RES_W:0]          sum_ext;
  logic                    acc_ovf;
  logic [RES_W-1:0]        sat_val;
  logic [RES_W-1:0]        acc_res;

  // Full-width product, sum, overflow detection and clamp value for one beat
  always_comb begin
    a_sx    = RES_W'($signed(bus.a_i));
    b_sx    = RES_W'($signed(bus.b_i));
    a_ux    = RES_W'(bus.a_i);
    b_ux    = RES_W'(bus.b_i);
    prod    = mode_q ? RES_W'(a_sx * b_sx) : RES_W'(a_ux * b_ux);
    sum_ext = {1'b0, res_q} + {1'b0, prod};
    if (mode_q) begin
      acc_ovf = (res_q[RES_W-1] == prod[RES_W-1]) &&
                (sum_ext[RES_W-1] != res_q[RES_W-1]);
      // Signed overflow direction follows the common sign of the addends
      sat_val = res_q[RES_W-1] ? {1'b1, {(RES_W-1){1'b0}}}
                               : {1'b0, {(RES_W-1){1'b1}}};
    end else begin
      acc_ovf = sum_ext[RES_W];
      sat_val = {RES_W{1'b1}};
    end
    acc_res = ((SATURATE != 0) && acc_ovf) ? sat_val : sum_ext[RES_W-1:0];
  end

  // Next-state: start has priority over any beat; beats count only in ACC
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    a_d     = bus.a_i;
    b_d     = bus.b_i;
    valid_d = bus.valid_i;
    if (bus.start_i) begin
      state_d = ACC;
      res_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      mode_d  = bus.signed_i;
    end else begin
      case (state_q)
        ACC: begin
          if (bus.valid_i) begin
            res_d = acc_res;
            ovf_d = ovf_q | acc_ovf;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DEPTH - 1)) begin
              state_d = DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign bus.a_o     = a_q;
  assign bus.b_o     = b_q;
  assign bus.valid_o = valid_q;
  assign bus.res_o   = res_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.busy_o  = (state_q == ACC);
  assign bus.done_o  = (state_q == DONE);
endmodule

// File: tb/tb_pe_mac_seq.sv
// Directed bench for pe_mac_seq with DATA_WIDTH=8, DEPTH=4; a wrapping and a
// saturating instance share the same stimulus.
module tb_pe_mac_seq;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sgn = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_mac_seq_if #(.DATA_WIDTH(DW)) bus0 ();
  pe_mac_seq_if #(.DATA_WIDTH(DW)) bus1 ();

  assign bus0.start_i = start;  assign bus1.start_i = start;
  assign bus0.signed_i = sgn;   assign bus1.signed_i = sgn;
  assign bus0.valid_i = valid;  assign bus1.valid_i = valid;
  assign bus0.a_i = a;          assign bus1.a_i = a;
  assign bus0.b_i = b;          assign bus1.b_i = b;

  pe_mac_seq #(.DATA_WIDTH(DW), .DEPTH(4), .SATURATE(0)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0));
  pe_mac_seq #(.DATA_WIDTH(DW), .DEPTH(4), .SATURATE(1)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1));

  // Apply one cycle of inputs at the falling edge, then sample 1ns after the rising edge
  task automatic drive(input logic s, input logic sg, input logic v,
                       input logic [DW-1:0] aa, input logic [DW-1:0] bb);
    @(negedge clk);
    start = s; sgn = sg; valid = v; a = aa; b = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (bus0.res_o !== 16'd0) begin n_fail++; $display("FAIL reset_res: got %h want 0000", bus0.res_o); end
    n_checks++; if ({bus0.busy_o, bus0.done_o, bus0.ovf_o, bus0.valid_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus0.busy_o, bus0.done_o, bus0.ovf_o, bus0.valid_o}); end
    n_checks++; if ({bus0.a_o, bus0.b_o} !== 16'h0000) begin n_fail++; $display("FAIL reset_fwd: got %h want 0000", {bus0.a_o, bus0.b_o}); end
  endtask

  task automatic test_unsigned();
    drive(1, 0, 0, 0, 0);
    n_checks++; if ({bus0.busy_o, bus0.done_o} !== 2'b10) begin n_fail++; $display("FAIL uns_start_state: got %b want 10", {bus0.busy_o, bus0.done_o}); end
    drive(0, 0, 1, 8'd3, 8'd4);
    drive(0, 0, 0, 8'd9, 8'd9);
    drive(0, 0, 1, 8'd5, 8'd6);
    n_checks++; if (bus0.res_o !== 16'd42) begin n_fail++; $display("FAIL uns_partial: got %0d want 42", bus0.res_o); end
    drive(0, 0, 1, 8'd255, 8'd255);
    n_checks++; if (bus0.done_o !== 1'b0) begin n_fail++; $display("FAIL uns_early_done: got %b want 0", bus0.done_o); end
    drive(0, 0, 1, 8'd1, 8'd1);
    n_checks++; if (bus0.res_o !== 16'hFE2C) begin n_fail++; $display("FAIL uns_res: got %h want fe2c", bus0.res_o); end
    n_checks++; if ({bus0.busy_o, bus0.done_o, bus0.ovf_o} !== 3'b010) begin n_fail++; $display("FAIL uns_flags: got %b want 010", {bus0.busy_o, bus0.done_o, bus0.ovf_o}); end
    drive(0, 0, 1, 8'd9, 8'd9);
    n_checks++; if (bus0.res_o !== 16'hFE2C || bus0.done_o !== 1'b1) begin n_fail++; $display("FAIL uns_done_hold: got %h/%b want fe2c/1", bus0.res_o, bus0.done_o); end
  endtask

  task automatic test_signed();
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 8'hFF, 8'h80);
    n_checks++; if (bus0.res_o !== 16'h0200) begin n_fail++; $display("FAIL sgn_res: got %h want 0200", bus0.res_o); end
    n_checks++; if ({bus0.done_o, bus0.ovf_o} !== 2'b10) begin n_fail++; $display("FAIL sgn_flags: got %b want 10", {bus0.done_o, bus0.ovf_o}); end
  endtask

  task automatic test_overflow();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 8'd255, 8'd255);
    drive(0, 0, 1, 8'd255, 8'd255);
    n_checks++; if (bus0.res_o !== 16'd64514 || bus0.ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_wrap: got %0d/%b want 64514/1", bus0.res_o, bus0.ovf_o); end
    n_checks++; if (bus1.res_o !== 16'd65535 || bus1.ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sat: got %0d/%b want 65535/1", bus1.res_o, bus1.ovf_o); end
    drive(0, 0, 1, 8'd1, 8'd1);
    n_checks++; if (bus0.res_o !== 16'd64515 || bus0.ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0d/%b want 64515/1", bus0.res_o, bus0.ovf_o); end
    n_checks++; if (bus1.res_o !== 16'd65535) begin n_fail++; $display("FAIL ovf_sat_hold: got %0d want 65535", bus1.res_o); end
    // Signed negative overflow: four beats of -128*127 = -16256
    drive(1, 1, 0, 0, 0);
    n_checks++; if (bus0.ovf_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", bus0.ovf_o); end
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 8'h80, 8'h7F);
    n_checks++; if (bus0.res_o !== 16'h0200 || bus0.ovf_o !== 1'b1) begin n_fail++; $display("FAIL sovf_wrap: got %h/%b want 0200/1", bus0.res_o, bus0.ovf_o); end
    n_checks++; if (bus1.res_o !== 16'h8000 || bus1.ovf_o !== 1'b1) begin n_fail++; $display("FAIL sovf_sat: got %h/%b want 8000/1", bus1.res_o, bus1.ovf_o); end
  endtask

  task automatic test_restart();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 8'd1, 8'd1);
    drive(0, 0, 1, 8'd2, 8'd2);
    n_checks++; if (bus0.res_o !== 16'd5) begin n_fail++; $display("FAIL rst_partial: got %0d want 5", bus0.res_o); end
    drive(1, 0, 1, 8'd7, 8'd7);
    n_checks++; if (bus0.res_o !== 16'd0 || bus0.busy_o !== 1'b1) begin n_fail++; $display("FAIL restart: got %0d/%b want 0/1", bus0.res_o, bus0.busy_o); end
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 8'd1, 8'd1);
    n_checks++; if (bus0.res_o !== 16'd3 || bus0.done_o !== 1'b0) begin n_fail++; $display("FAIL restart_3: got %0d/%b want 3/0", bus0.res_o, bus0.done_o); end
    drive(0, 0, 1, 8'd1, 8'd1);
    n_checks++; if (bus0.res_o !== 16'd4 || bus0.done_o !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %0d/%b want 4/1", bus0.res_o, bus0.done_o); end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 8'd3, 8'd3);
    n_checks++; if (bus0.res_o !== 16'd9) begin n_fail++; $display("FAIL ar_pre: got %0d want 9", bus0.res_o); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({bus0.res_o, bus0.a_o, bus0.b_o} !== 32'h0) begin n_fail++; $display("FAIL ar_data: got %h want 0", {bus0.res_o, bus0.a_o, bus0.b_o}); end
    n_checks++; if ({bus0.busy_o, bus0.done_o, bus0.ovf_o, bus0.valid_o} !== 4'b0000) begin n_fail++; $display("FAIL ar_flags: got %b want 0000", {bus0.busy_o, bus0.done_o, bus0.ovf_o, bus0.valid_o}); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'd5, 8'd5);
    n_checks++; if (bus0.res_o !== 16'd0 || bus0.done_o !== 1'b0 || bus0.busy_o !== 1'b0) begin n_fail++; $display("FAIL ar_ignore: got %0d/%b/%b want 0/0/0", bus0.res_o, bus0.done_o, bus0.busy_o); end
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 8'd1, 8'd2);
    n_checks++; if (bus0.res_o !== 16'd8 || bus0.done_o !== 1'b1) begin n_fail++; $display("FAIL ar_after: got %0d/%b want 8/1", bus0.res_o, bus0.done_o); end
  endtask

  task automatic test_forward();
    logic [DW-1:0] ea, eb;
    logic          ev;
    for (int i = 0; i < 60; i++) begin
      ea = DW'($urandom_range(0, 255));
      eb = DW'($urandom_range(0, 255));
      ev = ($urandom_range(0, 2) != 0);
      drive(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), ev, ea, eb);
      n_checks++; if ({bus0.a_o, bus0.b_o, bus0.valid_o} !== {ea, eb, ev}) begin n_fail++; $display("FAIL fwd_%0d: got %h want %h", i, {bus0.a_o, bus0.b_o, bus0.valid_o}, {ea, eb, ev}); end
      n_checks++; if ({bus1.a_o, bus1.b_o, bus1.valid_o} !== {ea, eb, ev}) begin n_fail++; $display("FAIL fwd_sat_%0d: got %h want %h", i, {bus1.a_o, bus1.b_o, bus1.valid_o}, {ea, eb, ev}); end
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_unsigned();
    test_signed();
    test_overflow();
    test_restart();
    test_async_reset();
    test_forward();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_mac_seq.md
PE_MAC_SEQ -- requirements
Module: pe_mac_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand width in bits.
REQ-002 Parameter DEPTH, default 4, number of valid beats per result (>=1).
REQ-003 Parameter SATURATE, default 0; 0 = wrap-around, 1 = clamp on overflow.
REQ-004 Derived RES_WIDTH = 2*DATA_WIDTH; counter width = clog2(DEPTH+1).
REQ-005 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 start_i  input  1  one-cycle pulse: clear accumulator and begin a new result.
REQ-008 signed_i  input  1  operand mode (1 = two's complement), sampled only when start_i is high.
REQ-009 valid_i  input  1  a_i/b_i carry a beat this cycle.
REQ-010 a_i, b_i  input  DATA_WIDTH each  operands.
REQ-011 a_o, b_o  output  DATA_WIDTH each  registered operand forward to the neighbouring PE.
REQ-012 valid_o  output  1  registered forward of valid_i.
REQ-013 res_o  output  RES_WIDTH  running/final accumulator.
REQ-014 busy_o  output  1  high in ACC.
REQ-015 done_o  output  1  high in DONE.
REQ-016 ovf_o  output  1  sticky overflow flag for the current result.

Function
REQ-017 a_o/b_o/valid_o SHALL equal a_i/b_i/valid_i delayed one cycle, in every state, independent of start_i.
REQ-018 FSM states IDLE, ACC, DONE; busy_o = (state==ACC), done_o = (state==DONE).
REQ-019 start_i in any state: next state ACC; res_o, beat count, ovf_o cleared to 0; mode latched from signed_i.
REQ-020 start_i has priority: a valid_i beat in the same cycle as start_i is not accumulated.
REQ-021 In ACC, each valid_i beat: res_o <= res_o + a_i*b_i (full RES_WIDTH product), count increments.
REQ-022 On the DEPTH-th beat's edge: res_o holds the final sum, state -> DONE, done_o high the next cycle.
REQ-023 Cycles with valid_i low in ACC: no change; gaps are unlimited.
REQ-024 valid_i in IDLE or DONE: forwarded only, not accumulated; DONE holds res_o, ovf_o until start_i.
REQ-025 Unsigned mode: overflow = carry out of RES_WIDTH; signed mode: addends of equal sign giving a sum of opposite sign.
REQ-026 Overflow sets ovf_o (stays set until start_i or reset).
REQ-027 SATURATE=0: res_o keeps the sum modulo 2^RES_WIDTH.
REQ-028 SATURATE=1: res_o clamps to max (unsigned all-ones; signed 2^(RES_WIDTH-1)-1) or signed min; later beats add to the clamped value.

Reset
REQ-029 rst_ni low SHALL immediately, without a clock, force state IDLE and all outputs, count and latched mode to 0.
REQ-030 Reset mid-ACC discards the partial result; after release, beats are ignored until start_i.

Verification (DATA_WIDTH=8, DEPTH=4)
REQ-031 Unsigned: start, beats (3,4),(5,6),(255,255),(1,1) -> res_o=65068 (16'hFE2C), done_o=1, ovf_o=0.
REQ-032 Signed: start with signed_i=1, four beats (8'hFF,8'h80) -> res_o=512 (16'h0200), ovf_o=0.
REQ-033 Unsigned, two beats (255,255) in one result: SATURATE=0 -> res_o=64514, ovf_o=1; SATURATE=1 -> res_o=65535, ovf_o=1.
REQ-034 start_i after 2 beats, with valid_i high in the same cycle -> res_o=0, busy_o=1; done_o only after 4 further beats.
REQ-035 rst_ni low between edges mid-ACC -> all outputs 0 at once; beats after release leave res_o=0 and done_o=0 until start_i.
REQ-036 Random valid_i gaps across all states -> a_o/b_o/valid_o always match inputs delayed one cycle.
